// File: rtl/dcache.sv
// dcache: direct-mapped, write-through / no-write-allocate data cache (16-byte lines).
// Latency: load hit or misaligned load responds 1 cycle after the request beat;
//   a miss responds 1 cycle after the 4th fill beat.
// Backpressure: dcache_ready is high only in IDLE; memory requests hold until mem_dc_ready.
// Ports:
//   clk, rst (async, active-low)
//   lsq_dc_*          request from the LSQ: op {type,store}, addr, lsqid, wdata, flush
//   dcache_*          ready, and load response: valid, error, lsqid, rdata
//   dc_mem_*/mem_dc_* memory side: line reads (4 beats), byte-masked word writes
module dcache #(
  parameter int NLINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsq_dc_req,
  input  logic [3:0]  lsq_dc_op,
  input  logic [31:0] lsq_dc_addr,
  input  logic [3:0]  lsq_dc_lsqid,
  input  logic [31:0] lsq_dc_wdata,
  input  logic        lsq_dc_flush,
  output logic        dcache_ready,
  output logic        dcache_valid,
  output logic        dcache_error,
  output logic [3:0]  dcache_lsqid,
  output logic [31:0] dcache_rdata,
  output logic        dc_mem_req,
  output logic        dc_mem_we,
  output logic [31:0] dc_mem_addr,
  output logic [31:0] dc_mem_wdata,
  output logic [3:0]  dc_mem_wmask,
  input  logic        mem_dc_ready,
  input  logic        mem_dc_valid,
  input  logic [31:0] mem_dc_rdata
);

  localparam int IW = $clog2(NLINES);
  localparam int TW = 28 - IW;

  typedef enum logic [2:0] {IDLE, RESP, FILL_REQ, FILL_DATA, STORE} state_t;

  state_t      state;
  logic [2:0]  type_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  lsqid_q;
  logic [1:0]  cnt;
  logic        kill;
  logic        resp_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [NLINES-1:0] line_vld;
  logic [TW-1:0]     tag_arr  [NLINES];
  logic [31:0]       data_arr [NLINES][4];

  // Misalignment depends only on access size: halves need addr[0]=0, words addr[1:0]=0.
  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
    case (t)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = a[0];
      default:        misaligned = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] t, input logic [1:0] a);
    case (t)
      3'b000, 3'b100: lane_mask = 4'b0001 << a;
      3'b001, 3'b101: lane_mask = 4'b0011 << a;
      default:        lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] t, input logic [1:0] a,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (t)
      3'b000:  extend = {{24{b[7]}}, b};
      3'b100:  extend = {24'b0, b};
      3'b001:  extend = {{16{h[15]}}, h};
      3'b101:  extend = {16'b0, h};
      default: extend = w;
    endcase
  endfunction

  logic          beat;
  logic [IW-1:0] in_idx;
  logic [TW-1:0] in_tag;
  logic [IW-1:0] q_idx;
  logic          in_hit;
  logic          in_mis;
  logic          in_store;
  logic [3:0]    in_mask;
  logic [31:0]   in_lanes;
  logic [31:0]   fill_word;

  assign dcache_ready = (state == IDLE);
  assign beat         = lsq_dc_req & dcache_ready & ~lsq_dc_flush;
  assign in_idx       = lsq_dc_addr[4+IW-1:4];
  assign in_tag       = lsq_dc_addr[31:4+IW];
  assign q_idx        = addr_q[4+IW-1:4];
  assign in_hit       = line_vld[in_idx] && (tag_arr[in_idx] == in_tag);
  assign in_mis       = misaligned(lsq_dc_op[3:1], lsq_dc_addr[1:0]);
  assign in_store     = lsq_dc_op[0];
  assign in_mask      = lane_mask(lsq_dc_op[3:1], lsq_dc_addr[1:0]);
  assign in_lanes     = lsq_dc_wdata << {lsq_dc_addr[1:0], 3'b000};
  // Word 3 arrives on the last beat and is not in the array yet; bypass it.
  assign fill_word    = (addr_q[3:2] == 2'd3) ? mem_dc_rdata : data_arr[q_idx][addr_q[3:2]];

  // A flush in the response cycle still cancels the response.
  assign dcache_valid = resp_q & ~lsq_dc_flush;
  assign dcache_error = err_q & ~lsq_dc_flush;
  assign dcache_lsqid = lsqid_q;
  assign dcache_rdata = rdata_q;

  assign dc_mem_req   = (state == FILL_REQ) || (state == STORE);
  assign dc_mem_we    = (state == STORE);
  assign dc_mem_addr  = (state == STORE) ? {addr_q[31:2], 2'b00} : {addr_q[31:4], 4'b0000};
  assign dc_mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
  assign dc_mem_wmask = (state == STORE) ? lane_mask(type_q, addr_q[1:0]) : 4'b0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      line_vld <= '0;
      type_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lsqid_q  <= '0;
      cnt      <= '0;
      kill     <= 1'b0;
      resp_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            type_q  <= lsq_dc_op[3:1];
            addr_q  <= lsq_dc_addr;
            wdata_q <= lsq_dc_wdata;
            lsqid_q <= lsq_dc_lsqid;
            cnt     <= '0;
            kill    <= 1'b0;
            if (in_store) begin
              // Misaligned stores are silently dropped.
              if (!in_mis) state <= STORE;
            end else if (in_mis) begin
              state   <= RESP;
              resp_q  <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else if (in_hit) begin
              state   <= RESP;
              resp_q  <= 1'b1;
              err_q   <= 1'b0;
              rdata_q <= extend(lsq_dc_op[3:1], lsq_dc_addr[1:0],
                                data_arr[in_idx][lsq_dc_addr[3:2]]);
            end else begin
              state <= FILL_REQ;
            end
          end
        end
        RESP: begin
          resp_q <= 1'b0;
          err_q  <= 1'b0;
          state  <= IDLE;
        end
        FILL_REQ: begin
          if (lsq_dc_flush) kill <= 1'b1;
          if (mem_dc_ready) state <= FILL_DATA;
        end
        FILL_DATA: begin
          if (lsq_dc_flush) kill <= 1'b1;
          if (mem_dc_valid) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              line_vld[q_idx] <= 1'b1;
              state           <= RESP;
              resp_q          <= ~(kill | lsq_dc_flush);
              err_q           <= 1'b0;
              rdata_q         <= extend(type_q, addr_q[1:0], fill_word);
            end
          end
        end
        STORE: begin
          if (mem_dc_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tag storage carry no reset; line_vld alone qualifies them.
  always_ff @(posedge clk) begin
    if (beat && in_store && !in_mis && in_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (in_mask[b]) data_arr[in_idx][lsq_dc_addr[3:2]][8*b +: 8] <= in_lanes[8*b +: 8];
      end
    end
    if (state == FILL_DATA && mem_dc_valid) begin
      data_arr[q_idx][cnt] <= mem_dc_rdata;
      if (cnt == 2'd3) tag_arr[q_idx] <= addr_q[31:4+IW];
    end
  end

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed table of load/store vectors against dcache with a scripted memory
// responder, plus hand sequences for reset state and reset in the middle of a fill.
module tb_dcache;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsq_dc_req;
  logic [3:0]  lsq_dc_op;
  logic [31:0] lsq_dc_addr;
  logic [3:0]  lsq_dc_lsqid;
  logic [31:0] lsq_dc_wdata;
  logic        lsq_dc_flush;
  logic        dcache_ready;
  logic        dcache_valid;
  logic        dcache_error;
  logic [3:0]  dcache_lsqid;
  logic [31:0] dcache_rdata;
  logic        dc_mem_req;
  logic        dc_mem_we;
  logic [31:0] dc_mem_addr;
  logic [31:0] dc_mem_wdata;
  logic [3:0]  dc_mem_wmask;
  logic        mem_dc_ready;
  logic        mem_dc_valid;
  logic [31:0] mem_dc_rdata;

  dcache #(.NLINES(64)) dut (
    .clk(clk), .rst(rst),
    .lsq_dc_req(lsq_dc_req), .lsq_dc_op(lsq_dc_op), .lsq_dc_addr(lsq_dc_addr),
    .lsq_dc_lsqid(lsq_dc_lsqid), .lsq_dc_wdata(lsq_dc_wdata), .lsq_dc_flush(lsq_dc_flush),
    .dcache_ready(dcache_ready), .dcache_valid(dcache_valid), .dcache_error(dcache_error),
    .dcache_lsqid(dcache_lsqid), .dcache_rdata(dcache_rdata),
    .dc_mem_req(dc_mem_req), .dc_mem_we(dc_mem_we), .dc_mem_addr(dc_mem_addr),
    .dc_mem_wdata(dc_mem_wdata), .dc_mem_wmask(dc_mem_wmask),
    .mem_dc_ready(mem_dc_ready), .mem_dc_valid(mem_dc_valid), .mem_dc_rdata(mem_dc_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [31:0]  addr;
    logic [3:0]   id;
    logic [31:0]  wdata;
    logic [127:0] line;     // word i at [32*i +: 32], served if a fill happens
    bit           flush;    // pulse flush during the third fill beat
    int           stall;    // cycles to hold mem_dc_ready low on a write
    bit           rd;
    logic [31:0]  rd_addr;
    bit           wr;
    logic [31:0]  wr_addr;
    logic [31:0]  wr_data;
    logic [3:0]   wr_mask;
    bit           vld;
    bit           err;
    logic [31:0]  rdata;
  } vec_t;

  localparam logic [3:0] LB = 4'h0, SB = 4'h1, LH = 4'h2, SH = 4'h3, LW = 4'h4, SW = 4'h5,
                         LX = 4'h6, LBU = 4'h8, LHU = 4'hA;

  localparam logic [127:0] L100 = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] L400 = {32'h43, 32'h42, 32'h41, 32'h40};
  localparam logic [127:0] L500 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] L300 = {32'h0, 32'h0, 32'h0, 32'h77665544};

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic add_ld(input logic [3:0] op, input logic [31:0] addr, input logic [3:0] id,
                        input bit rd, input logic [127:0] line, input bit flush,
                        input bit err, input logic [31:0] rdata);
    vec_t v;
    v = '{op: op, addr: addr, id: id, wdata: 32'h0, line: line, flush: flush, stall: 0,
          rd: rd, rd_addr: {addr[31:4], 4'h0}, wr: 1'b0, wr_addr: 32'h0, wr_data: 32'h0,
          wr_mask: 4'h0, vld: !flush, err: err, rdata: rdata};
    tbl.push_back(v);
  endtask

  task automatic add_st(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input int stall, input bit wr, input logic [31:0] wr_addr,
                        input logic [31:0] wr_data, input logic [3:0] wr_mask);
    vec_t v;
    v = '{op: op, addr: addr, id: 4'h0, wdata: wdata, line: 128'h0, flush: 1'b0, stall: stall,
          rd: 1'b0, rd_addr: 32'h0, wr: wr, wr_addr: wr_addr, wr_data: wr_data,
          wr_mask: wr_mask, vld: 1'b0, err: 1'b0, rdata: 32'h0};
    tbl.push_back(v);
  endtask

  // Issue one request at a slot (#1 after posedge), then play memory until idle again.
  task automatic run_vec(input int idx, input vec_t v);
    int          vcnt, first_v, rd_n, wr_n, stall_n, beat;
    bit          fill, done;
    logic [31:0] rd_a, wr_a, wr_d, got_d;
    logic [3:0]  wr_m, got_id;
    logic        got_e;
    logic [127:0] ln;
    string       p;
    p = $sformatf("v%0d", idx);
    vcnt = 0; first_v = -1; rd_n = 0; wr_n = 0; stall_n = 0; beat = 0;
    fill = 0; done = 0; rd_a = 0; wr_a = 0; wr_d = 0; wr_m = 0; got_d = 0; got_id = 0; got_e = 0;
    ln = v.line;
    lsq_dc_req = 1'b1; lsq_dc_op = v.op; lsq_dc_addr = v.addr;
    lsq_dc_lsqid = v.id; lsq_dc_wdata = v.wdata;
    @(posedge clk); #1;
    lsq_dc_req = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (dcache_valid) begin
        vcnt++;
        if (first_v < 0) first_v = cyc;
        got_d = dcache_rdata; got_e = dcache_error; got_id = dcache_lsqid;
      end
      mem_dc_ready = 1'b0; mem_dc_valid = 1'b0; lsq_dc_flush = 1'b0; mem_dc_rdata = 32'h0;
      if (dc_mem_req && !dc_mem_we) begin
        rd_n++; rd_a = dc_mem_addr; mem_dc_ready = 1'b1; fill = 1; beat = 0;
      end else if (dc_mem_req && dc_mem_we) begin
        if (stall_n == 0) begin
          wr_a = dc_mem_addr; wr_d = dc_mem_wdata; wr_m = dc_mem_wmask;
        end else begin
          chk({p, " stall addr"},  dc_mem_addr,  wr_a);
          chk({p, " stall wdata"}, dc_mem_wdata, wr_d);
          chk({p, " stall ready"}, {31'b0, dcache_ready}, 32'h0);
        end
        if (stall_n < v.stall) stall_n++;
        else begin
          mem_dc_ready = 1'b1; wr_n++;
        end
      end else if (fill && beat < 4) begin
        mem_dc_valid = 1'b1;
        mem_dc_rdata = ln[32*beat +: 32];
        if (v.flush && beat == 2) lsq_dc_flush = 1'b1;
        beat++;
      end else if (dcache_ready) begin
        done = 1;
      end
      @(posedge clk); #1;
    end
    mem_dc_ready = 1'b0; mem_dc_valid = 1'b0; lsq_dc_flush = 1'b0;
    if (!done) chk({p, " timeout"}, 32'h1, 32'h0);
    chk({p, " resp count"}, vcnt, {31'b0, v.vld});
    chk({p, " mem reads"},  rd_n, {31'b0, v.rd});
    chk({p, " mem writes"}, wr_n, {31'b0, v.wr});
    if (v.rd) chk({p, " rd addr"}, rd_a, v.rd_addr);
    if (v.wr) begin
      chk({p, " wr addr"},  wr_a, v.wr_addr);
      chk({p, " wr data"},  wr_d, v.wr_data);
      chk({p, " wr mask"},  {28'b0, wr_m}, {28'b0, v.wr_mask});
    end
    if (v.vld) begin
      chk({p, " rdata"}, got_d, v.rdata);
      chk({p, " error"}, {31'b0, got_e}, {31'b0, v.err});
      chk({p, " lsqid"}, {28'b0, got_id}, {28'b0, v.id});
      if (!v.rd) chk({p, " hit latency"}, first_v, 32'h0);
    end
  endtask

  initial begin
    vec_t post;
    int   stray_v, stray_busy;
    rst = 1'b0; lsq_dc_req = 0; lsq_dc_op = 0; lsq_dc_addr = 0; lsq_dc_lsqid = 0;
    lsq_dc_wdata = 0; lsq_dc_flush = 0; mem_dc_ready = 0; mem_dc_valid = 0; mem_dc_rdata = 0;

    add_ld(LW,  32'h100, 4'd3,  1, L100, 0, 0, 32'h11);
    add_st(SW,  32'h108, 32'h80FF0033, 0, 1, 32'h108, 32'h80FF0033, 4'hF);
    add_ld(LB,  32'h10B, 4'd5,  0, 0, 0, 0, 32'hFFFFFF80);
    add_ld(LBU, 32'h10B, 4'd6,  0, 0, 0, 0, 32'h00000080);
    add_ld(LB,  32'h10A, 4'd7,  0, 0, 0, 0, 32'hFFFFFFFF);
    add_ld(LH,  32'h10A, 4'd8,  0, 0, 0, 0, 32'hFFFF80FF);
    add_ld(LHU, 32'h108, 4'd9,  0, 0, 0, 0, 32'h00000033);
    add_st(SH,  32'h106, 32'h0000BEEF, 0, 1, 32'h104, 32'hBEEF0000, 4'hC);
    add_ld(LHU, 32'h106, 4'd1,  0, 0, 0, 0, 32'h0000BEEF);
    add_ld(LW,  32'h104, 4'd2,  0, 0, 0, 0, 32'hBEEF0022);
    add_ld(LW,  32'h202, 4'd4,  0, 0, 0, 1, 32'h0);
    add_ld(LH,  32'h201, 4'd4,  0, 0, 0, 1, 32'h0);
    add_st(SH,  32'h105, 32'h00001234, 0, 0, 0, 0, 0);
    add_ld(LX,  32'h104, 4'd10, 0, 0, 0, 0, 32'hBEEF0022);
    add_st(SB,  32'h401, 32'h000000AB, 0, 1, 32'h400, 32'h0000AB00, 4'h2);
    add_ld(LW,  32'h400, 4'd11, 1, L400, 0, 0, 32'h40);
    add_ld(LW,  32'h50C, 4'd12, 1, L500, 0, 0, 32'hA3);
    add_ld(LW,  32'h100, 4'd13, 1, L100, 0, 0, 32'h11);
    add_st(SW,  32'h10C, 32'h12345678, 5, 1, 32'h10C, 32'h12345678, 4'hF);
    add_ld(LW,  32'h10C, 4'd14, 0, 0, 0, 0, 32'h12345678);
    add_ld(LBU, 32'h302, 4'd15, 1, L300, 1, 0, 32'h0);
    add_ld(LBU, 32'h302, 4'd15, 0, 0, 0, 0, 32'h66);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", {31'b0, dcache_valid}, 32'h0);
    chk("rst error", {31'b0, dcache_error}, 32'h0);
    chk("rst mem_req", {31'b0, dc_mem_req}, 32'h0);
    chk("rst mem_we", {31'b0, dc_mem_we}, 32'h0);
    chk("rst wmask", {28'b0, dc_mem_wmask}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst ready", {31'b0, dcache_ready}, 32'h1);

    for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

    // Reset in the middle of a fill
    lsq_dc_req = 1'b1; lsq_dc_op = LW; lsq_dc_addr = 32'h600; lsq_dc_lsqid = 4'd2;
    @(posedge clk); #1;
    lsq_dc_req = 1'b0;
    chk("mf mem_req", {31'b0, dc_mem_req}, 32'h1);
    mem_dc_ready = 1'b1;
    @(posedge clk); #1;
    mem_dc_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_dc_valid = 1'b1; mem_dc_rdata = 32'hD0 + b;
      @(posedge clk); #1;
    end
    mem_dc_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mf ready", {31'b0, dcache_ready}, 32'h1);
    chk("mf mem_req", {31'b0, dc_mem_req}, 32'h0);
    chk("mf valid", {31'b0, dcache_valid}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    stray_v = 0; stray_busy = 0;
    for (int c = 0; c < 6; c++) begin
      mem_dc_valid = 1'b1; mem_dc_rdata = 32'hEE;
      @(posedge clk); #1;
      if (dcache_valid) stray_v++;
      if (!dcache_ready) stray_busy++;
    end
    mem_dc_valid = 1'b0;
    chk("mf no resp", stray_v, 32'h0);
    chk("mf stays idle", stray_busy, 32'h0);

    // Lines were invalidated: a previously cached address must refill.
    post = '{op: LW, addr: 32'h300, id: 4'd6, wdata: 32'h0, line: L300, flush: 1'b0, stall: 0,
             rd: 1'b1, rd_addr: 32'h300, wr: 1'b0, wr_addr: 32'h0, wr_data: 32'h0,
             wr_mask: 4'h0, vld: 1'b1, err: 1'b0, rdata: 32'h77665544};
    run_vec(99, post);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
